// File: rtl/argmax_pkg.sv
// Shared argmax definitions: frame FSM state, index-width helper and a
// signed/unsigned "strictly greater" compare used by every argmax variant.
package argmax_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_bits(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  // Strict a > b on width-bit values held zero-extended in 64 bits.
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic value_gt(input logic [63:0] a, input logic [63:0] b,
                                    input int width, input bit is_signed);
    logic [63:0] flip;
    flip = is_signed ? (64'd1 << (width - 1)) : 64'd0;
    return (a ^ flip) > (b ^ flip);
  endfunction

endpackage

// File: rtl/argmax_lane_tree.sv
// Combinational binary reduction of LANES values to the winning value and its
// lane index. Strict compare at every node: the lower-lane input wins ties.
module argmax_lane_tree
  import argmax_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LANES      = 4,
  parameter int SIGNED     = 1,
  parameter int LANE_IDX_W = idx_bits(LANES)
) (
  input  logic [LANES*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]       max_o,
  output logic [LANE_IDX_W-1:0]  idx_o
);

  localparam int LEVELS = $clog2(LANES);

  genvar gl, gi;
  generate
    for (gl = 0; gl <= LEVELS; gl++) begin : g_lvl
      localparam int N = LANES >> gl;
      logic [WIDTH-1:0]      val [N];
      logic [LANE_IDX_W-1:0] idx [N];
      if (gl == 0) begin : g_leaf
        for (gi = 0; gi < N; gi++) begin : g_in
          assign val[gi] = data_i[gi*WIDTH +: WIDTH];
          assign idx[gi] = LANE_IDX_W'(gi);
        end
      end else begin : g_node
        for (gi = 0; gi < N; gi++) begin : g_cmp
          logic take_hi;
          // Upper half replaces the lower half only when strictly greater.
          assign take_hi = value_gt(64'(g_lvl[gl-1].val[2*gi+1]),
                                    64'(g_lvl[gl-1].val[2*gi]), WIDTH, SIGNED != 0);
          assign val[gi] = take_hi ? g_lvl[gl-1].val[2*gi+1] : g_lvl[gl-1].val[2*gi];
          assign idx[gi] = take_hi ? g_lvl[gl-1].idx[2*gi+1] : g_lvl[gl-1].idx[2*gi];
        end
      end
    end
  endgenerate

  assign max_o = g_lvl[LEVELS].val[0];
  assign idx_o = g_lvl[LEVELS].idx[0];

endmodule

// File: rtl/serial_parallel_argmax_stream.sv
// Frame-level streaming argmax: each beat is reduced by argmax_lane_tree, the
// beat winners are merged serially into one result per frame.
// Optional build macro ARGMAX_PIPE_EN inserts a register stage after the lane
// tree (result latency t+2, next-frame beats may enter while a result waits).
module serial_parallel_argmax_stream
  import argmax_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int MAX_BEATS = 16,
  parameter int SIGNED    = 1,
  parameter int IDX_WIDTH = idx_bits(LANES * MAX_BEATS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_WIDTH-1:0]   out_argmax,
  output logic [WIDTH-1:0]       out_max,
  output logic                   out_overflow
);

  localparam int CW = idx_bits(MAX_BEATS);
  localparam int LW = idx_bits(LANES);

  // Input-side frame tracking
  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            sat_q;

  logic [WIDTH-1:0]     tree_max;
  logic [LW-1:0]        tree_lane;
  logic                 beat_fire;
  logic                 beat_first;
  logic                 beat_ovf;
  logic [IDX_WIDTH-1:0] beat_idx;

  // Merge-side view of a beat (either the live input or the pipe stage)
  logic                 proc_fire;
  logic                 proc_first;
  logic                 proc_ovf;
  logic                 proc_last;
  logic [WIDTH-1:0]     proc_max;
  logic [IDX_WIDTH-1:0] proc_idx;

  // Running frame winner
  logic [WIDTH-1:0]     acc_max_q, acc_max_d;
  logic [IDX_WIDTH-1:0] acc_idx_q, acc_idx_d;
  logic                 acc_ovf_q, acc_ovf_d;
  logic                 beat_better;

  logic                 out_valid_q;
  logic [IDX_WIDTH-1:0] out_argmax_q;
  logic [WIDTH-1:0]     out_max_q;
  logic                 out_ovf_q;

  argmax_lane_tree #(
    .WIDTH      (WIDTH),
    .LANES      (LANES),
    .SIGNED     (SIGNED),
    .LANE_IDX_W (LW)
  ) u_tree (
    .data_i (in_data),
    .max_o  (tree_max),
    .idx_o  (tree_lane)
  );

  assign beat_fire  = in_valid && in_ready;
  assign beat_first = (state_q == IDLE);
  // Once beat MAX_BEATS-1 has been taken the counter is saturated; any later
  // beat of the same frame is an overflow beat.
  assign beat_ovf   = !beat_first && sat_q;
  assign beat_idx   = IDX_WIDTH'(int'(cnt_q) * LANES + int'(tree_lane));

  // Frame FSM and saturating beat counter, advanced on every accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else if (beat_fire) begin
      if (in_last) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        sat_q   <= 1'b0;
      end else begin
        state_q <= ACCUM;
        if (cnt_q == CW'(MAX_BEATS - 1)) sat_q <= 1'b1;
        else                             cnt_q <= cnt_q + CW'(1);
      end
    end
  end

`ifdef ARGMAX_PIPE_EN
  logic                 stg_valid_q;
  logic                 stg_first_q;
  logic                 stg_ovf_q;
  logic                 stg_last_q;
  logic [WIDTH-1:0]     stg_max_q;
  logic [IDX_WIDTH-1:0] stg_idx_q;

  // Only a staged last beat that cannot reach a busy output register stalls.
  assign in_ready = !(stg_valid_q && stg_last_q && out_valid_q && !out_ready);

  // Stage after the lane tree; frozen whenever the input is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid_q <= 1'b0;
      stg_first_q <= 1'b0;
      stg_ovf_q   <= 1'b0;
      stg_last_q  <= 1'b0;
      stg_max_q   <= '0;
      stg_idx_q   <= '0;
    end else if (in_ready) begin
      stg_valid_q <= in_valid;
      if (in_valid) begin
        stg_first_q <= beat_first;
        stg_ovf_q   <= beat_ovf;
        stg_last_q  <= in_last;
        stg_max_q   <= tree_max;
        stg_idx_q   <= beat_idx;
      end
    end
  end

  assign proc_fire  = stg_valid_q && in_ready;
  assign proc_first = stg_first_q;
  assign proc_ovf   = stg_ovf_q;
  assign proc_last  = stg_last_q;
  assign proc_max   = stg_max_q;
  assign proc_idx   = stg_idx_q;
`else
  assign in_ready   = !out_valid_q || out_ready;

  assign proc_fire  = beat_fire;
  assign proc_first = beat_first;
  assign proc_ovf   = beat_ovf;
  assign proc_last  = in_last;
  assign proc_max   = tree_max;
  assign proc_idx   = beat_idx;
`endif

  // Merge the beat winner into the frame winner; the earlier index keeps ties
  always_comb begin
    beat_better = value_gt(64'(proc_max), 64'(acc_max_q), WIDTH, SIGNED != 0);
    acc_max_d   = acc_max_q;
    acc_idx_d   = acc_idx_q;
    acc_ovf_d   = acc_ovf_q;
    if (proc_first) begin
      acc_max_d = proc_max;
      acc_idx_d = proc_idx;
      acc_ovf_d = proc_ovf;
    end else if (proc_ovf) begin
      acc_ovf_d = 1'b1;
    end else if (beat_better) begin
      acc_max_d = proc_max;
      acc_idx_d = proc_idx;
    end
  end

  // Frame accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_max_q <= '0;
      acc_idx_q <= '0;
      acc_ovf_q <= 1'b0;
    end else if (proc_fire) begin
      acc_max_q <= acc_max_d;
      acc_idx_q <= acc_idx_d;
      acc_ovf_q <= acc_ovf_d;
    end
  end

  // Output register: loads on a merged last beat, otherwise drains on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_argmax_q <= '0;
      out_max_q    <= '0;
      out_ovf_q    <= 1'b0;
    end else if (proc_fire && proc_last) begin
      out_valid_q  <= 1'b1;
      out_argmax_q <= acc_idx_d;
      out_max_q    <= acc_max_d;
      out_ovf_q    <= acc_ovf_d;
    end else if (out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_argmax   = out_argmax_q;
  assign out_max      = out_max_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_serial_parallel_argmax_stream.sv
// Bench for serial_parallel_argmax_stream: a signed and an unsigned instance
// (MAX_BEATS=4) share one stimulus stream; a scoreboard holds the expected
// frame results and a monitor compares each delivered result.
// Works in either build (ARGMAX_PIPE_EN defined or not).
module tb_serial_parallel_argmax_stream;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready;

  logic       in_ready_s, out_valid_s, out_overflow_s;
  logic [3:0] out_argmax_s;
  logic [7:0] out_max_s;
  logic       in_ready_u, out_valid_u, out_overflow_u;
  logic [3:0] out_argmax_u;
  logic [7:0] out_max_u;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] mx;
    logic       ovf;
  } res_t;

  res_t        q_s[$];
  res_t        q_u[$];
  logic [31:0] cur_frame[$];
  res_t        mon_e;

  int vectors = 0;
  int miscompares = 0;
  bit ready_rand = 1'b0;
  bit ready_force = 1'b1;
  bit gaps = 1'b0;

  always #5 clk = ~clk;

  serial_parallel_argmax_stream #(
    .WIDTH(W), .LANES(L), .MAX_BEATS(MB), .SIGNED(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_argmax(out_argmax_s), .out_max(out_max_s),
    .out_overflow(out_overflow_s)
  );

  serial_parallel_argmax_stream #(
    .WIDTH(W), .LANES(L), .MAX_BEATS(MB), .SIGNED(0)
  ) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_argmax(out_argmax_u), .out_max(out_max_u),
    .out_overflow(out_overflow_u)
  );

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Reference: flat scan of the first MB beats in index order, strict greater.
  function automatic res_t model(input bit sgn);
    res_t        r;
    logic [31:0] bt;
    logic [7:0]  v;
    bit          have;
    bit          gt;
    r = '0;
    have = 1'b0;
    for (int b = 0; b < cur_frame.size() && b < MB; b++) begin
      bt = cur_frame[b];
      for (int l = 0; l < L; l++) begin
        v  = bt[l*8 +: 8];
        gt = sgn ? ($signed(v) > $signed(r.mx)) : (v > r.mx);
        if (!have || gt) begin
          r.mx  = v;
          r.idx = 4'(b * L + l);
          have  = 1'b1;
        end
      end
    end
    r.ovf = (cur_frame.size() > MB);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // out_ready changes only just after a rising edge
  always @(posedge clk) begin
    #2;
    out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Output monitor: a handshake seen here completes at the next rising edge
  always @(negedge clk) begin
    if (rst_n && out_ready && out_valid_s) begin
      if (q_s.size() == 0) check("s_unexpected_result", 32'd1, 32'd0);
      else begin
        mon_e = q_s.pop_front();
        $display("signed   result: argmax=%0d max=%0d ovf=%0b (exp %0d/%0d/%0b)",
                 out_argmax_s, $signed(out_max_s), out_overflow_s, mon_e.idx, $signed(mon_e.mx), mon_e.ovf);
        check("s_argmax", 32'(out_argmax_s), 32'(mon_e.idx));
        check("s_max", 32'(out_max_s), 32'(mon_e.mx));
        check("s_overflow", 32'(out_overflow_s), 32'(mon_e.ovf));
      end
    end
    if (rst_n && out_ready && out_valid_u) begin
      if (q_u.size() == 0) check("u_unexpected_result", 32'd1, 32'd0);
      else begin
        mon_e = q_u.pop_front();
        $display("unsigned result: argmax=%0d max=%0d ovf=%0b (exp %0d/%0d/%0b)",
                 out_argmax_u, out_max_u, out_overflow_u, mon_e.idx, mon_e.mx, mon_e.ovf);
        check("u_argmax", 32'(out_argmax_u), 32'(mon_e.idx));
        check("u_max", 32'(out_max_u), 32'(mon_e.mx));
        check("u_overflow", 32'(out_overflow_u), 32'(mon_e.ovf));
      end
    end
  end

  // Present one beat; entered and left just after a rising edge.
  task automatic send_beat(input logic [31:0] d, input bit last, input int budget,
                           input bit must, output bit got);
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (in_ready_s && in_ready_u) begin
        got = 1'b1;
        break;
      end
    end
    if (must) check("accept_within_budget", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (got) begin
      cur_frame.push_back(d);
      if (last) begin
        q_s.push_back(model(1'b1));
        q_u.push_back(model(1'b0));
        cur_frame.delete();
      end
    end
  endtask

  task automatic beat(input logic [31:0] d, input bit last);
    bit got;
    send_beat(d, last, 300, 1'b1, got);
  endtask

  task automatic drain();
    int c;
    for (c = 0; c < 2000; c++) begin
      if (q_s.size() == 0 && q_u.size() == 0) break;
      @(posedge clk);
    end
    check("drain_pending", 32'(q_s.size() + q_u.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_out_valid_s", 32'(out_valid_s), 32'd0);
    check("rst_out_argmax_s", 32'(out_argmax_s), 32'd0);
    check("rst_out_max_s", 32'(out_max_s), 32'd0);
    check("rst_out_overflow_s", 32'(out_overflow_s), 32'd0);
    check("rst_in_ready_s", 32'(in_ready_s), 32'd1);
    check("rst_out_valid_u", 32'(out_valid_u), 32'd0);
    check("rst_out_max_u", 32'(out_max_u), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got_b;
    logic [31:0] rd;
    int nb;

    // Reset values
    #12;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Lane tie inside one beat: lower lane wins
    beat(pack(3, 9, 9, -2), 1'b1);
    // Three-beat frame; -8 wins only in the unsigned instance
    beat(pack(1, 2, 3, 4), 1'b0);
    beat(pack(7, 0, 0, 0), 1'b0);
    beat(pack(7, 8, -8, 0), 1'b1);
    // Equal maxima across beats: earliest index kept
    beat(pack(7, 7, 0, 0), 1'b0);
    beat(pack(0, 7, 0, 0), 1'b1);
    // Six beats with MAX_BEATS=4: beats 4 and 5 must be ignored, overflow set
    for (int b = 0; b < 4; b++) beat(pack(b, b + 1, 2, 0), 1'b0);
    beat(pack(50, 60, 0, 0), 1'b0);
    beat(pack(0, 0, 100, 0), 1'b1);
    // Exactly MAX_BEATS beats: no overflow
    for (int b = 0; b < 4; b++) beat(pack(0, 0, b * 10, 1), b == 3);
    // Back-to-back single-beat frames
    for (int f = 0; f < 4; f++) beat(pack(f, 20 - f, -f, 5), 1'b1);
    drain();

    // Output stall: first result must be held, input must stop
    ready_force = 1'b0;
    @(posedge clk);
    #3;
    beat(pack(10, 20, 30, 40), 1'b1);
    send_beat(pack(-1, 66, 2, 66), 1'b1, 6, 1'b0, got_b);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stall_in_ready_low", 32'(in_ready_s), 32'd0);
    check("stall_out_valid", 32'(out_valid_s), 32'd1);
    check("stall_out_max_held", 32'(out_max_s), 32'd40);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("stall_out_argmax_held", 32'(out_argmax_s), 32'd3);
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    if (!got_b) beat(pack(-1, 66, 2, 66), 1'b1);
    drain();

    // Reset in the middle of a frame discards it
    beat(pack(9, 9, 9, 9), 1'b0);
    beat(pack(100, 0, 0, 0), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    cur_frame.delete();
    #2;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(pack(5, 0, 0, 0), 1'b1);
    drain();

    // Random frames with random gaps and back-pressure
    gaps = 1'b1;
    ready_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        for (int l = 0; l < L; l++) rd[l*8 +: 8] = 8'($urandom_range(0, 15) - 8);
        beat(rd, b == nb - 1);
      end
    end
    drain();
    ready_rand = 1'b0;
    gaps = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_parallel_argmax_stream.md
# serial_parallel_argmax_stream

Streaming frame-level argmax over a `LANES`-wide input bus, with valid/ready handshakes on both sides. Each beat carries `LANES` values. The block reduces them in parallel, keeps a running maximum across the beats of a frame, and emits one result per frame: the winning value, its flat index and an overflow flag. It sits between classifier output layers and downstream decision logic, where per-beat parallel partial results must be merged serially into one winner.

## Interface
- `WIDTH`, 8: bits per value.
- `LANES`, 4: values per beat; power of two, ≥1.
- `MAX_BEATS`, 16: beats per frame that are indexed and compared; power of two.
- `SIGNED`, 1: 1 = two's-complement compare, 0 = unsigned compare.
- `IDX_WIDTH`, `$clog2(LANES*MAX_BEATS)` (derived): index width; minimum 1.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: beat valid.
- `in_ready` output 1: block accepts the beat this cycle.
- `in_data` input `LANES*WIDTH`: lane i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_last` input 1: final beat of the frame.
- `out_valid` output 1: frame result available.
- `out_ready` input 1: consumer takes the result.
- `out_argmax` output `IDX_WIDTH`: flat index of the winner, `beat*LANES + lane`.
- `out_max` output `WIDTH`: winning value.
- `out_overflow` output 1: the frame had more than `MAX_BEATS` beats.

## Operation
- A beat is accepted when `in_valid && in_ready`. Nothing happens on unaccepted cycles.
- Lane reduction: a binary tree of compares. Strict greater-than; a lower lane wins ties.
- Frame accumulation:
  - The first accepted beat of a frame loads the accumulator directly. It does not compare against stale state.
  - Later beats replace the accumulator only when the beat winner is strictly greater. The earliest index wins ties.
- Beat counter: `$clog2(MAX_BEATS)` bits. Increments per accepted beat and clears after the `in_last` beat.
- Overflow:
  - Beats past `MAX_BEATS` are still accepted but are not compared.
  - They set a sticky frame-overflow bit. The counter saturates and does not wrap.
- State machine:
  - IDLE (no frame open): first accepted beat → ACCUM, or stays in IDLE if that beat also has `in_last` set.
  - ACCUM: an accepted `in_last` → IDLE.
  - On the `in_last` beat, the final winner and overflow bit load into the output register and `out_valid` is set.
- Output register holds stable while `out_valid && !out_ready`. It clears `out_valid` on handshake unless a new result loads in the same cycle.
- Reset, including mid-frame: state IDLE, counter 0, overflow 0, `out_valid` 0, `out_argmax` 0, `out_max` 0, `out_overflow` 0. A partial frame is discarded.

## Timing
- No pipe stage: `in_ready = !out_valid || out_ready`, purely combinational. A last beat accepted at cycle t gives `out_valid` at t+1.
- Back-to-back single-beat frames sustain 1 result per cycle while `out_ready` is high.
- Simultaneous output handshake and new last beat: the new result loads and `out_valid` stays 1.
- `in_ready` never depends combinationally on `in_valid`.

## Configuration
- `ARGMAX_PIPE_EN` defined:
  - A register stage is inserted after the lane tree. It holds the beat winner, its index, last and overflow status.
  - Latency becomes t+2.
  - `in_ready = !(stage_valid && stage_last && out_valid && !out_ready)`. The stage holds its contents while stalled.
  - Beats of the next frame may enter while the previous result is in flight.
- `ARGMAX_PIPE_EN` undefined: no stage; behaviour as in Timing.
- Results are identical in both builds; only latency and `in_ready` differ.

## Structure
- Shared package `argmax_pkg`:
  - compare function, taking `SIGNED` as an argument;
  - index-width helper function;
  - state enum (IDLE, ACCUM).
- One sub-module: `argmax_lane_tree`, a combinational reduction from `LANES` values to the winning value and its lane index. It is reused by other argmax variants.

## Test plan
- `LANES`=4, one beat {3,9,9,−2}, last → `out_argmax`=1, `out_max`=9.
- Frame of 3 beats {1,2,3,4}, {7,0,0,0}, {7,8,−8,0}, `SIGNED`=1 → argmax=9, max=8. With `SIGNED`=0, −8 reads as 248 → argmax=10.
- `MAX_BEATS`=4, 6-beat frame with the global max in beat 5 → overflow=1; the winner comes from beats 0–3 only.
- Hold `out_ready`=0 with two frames queued → `in_ready` drops and the first result stays stable. Release → results arrive in order with no loss.
- Assert `rst_n` low mid-frame, then send a 1-beat frame {5,0,0,0} → argmax=0, max=5, no stale winner.
- Random frames with random `in_valid`/`out_ready` in both macro builds → results match a reference model; only latency differs.
